// File: rtl/minmax_select_pipe.sv
// Pipelined N-channel min/max selector with channel index, plus a frame
// accumulator that tracks the extremum across beats delimited by in_last.
module minmax_select_pipe #(
    parameter int WIDTH  = 8,
    parameter int CH     = 3,
    parameter int SIGNED = 0,
    parameter int POSW   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic [CH*WIDTH-1:0]                    in_data,
    input  logic                                   in_mode,
    input  logic                                   in_last,
    output logic                                   out_valid,
    output logic [WIDTH-1:0]                       out_data,
    output logic [((CH > 2) ? $clog2(CH) : 1)-1:0] out_idx,
    output logic                                   frame_valid,
    output logic [WIDTH-1:0]                       frame_data,
    output logic [((CH > 2) ? $clog2(CH) : 1)-1:0] frame_idx,
    output logic [POSW-1:0]                        frame_pos,
    output logic                                   frame_err
);

    localparam int IW = (CH > 2) ? $clog2(CH) : 1;
    localparam int L  = $clog2(CH);

    function automatic int f_nodes(input int lvl);
        int n;
        n = CH;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    // True when cand strictly beats base; equal values never win, so ties keep
    // the lower-index operand.
    function automatic logic f_better(input logic [WIDTH-1:0] cand,
                                      input logic [WIDTH-1:0] base,
                                      input logic             mode);
        logic               sx;
        logic signed [WIDTH:0] c;
        logic signed [WIDTH:0] b;
        sx = (SIGNED != 0);
        c  = {sx & cand[WIDTH-1], cand};
        b  = {sx & base[WIDTH-1], base};
        return mode ? (c > b) : (c < b);
    endfunction

    function automatic logic [POSW-1:0] f_sat_inc(input logic [POSW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        logic w_vld;
        logic w_mode;
        logic w_last;

        if (l == 0) begin : g_ctl_in
            assign w_vld  = in_valid;
            assign w_mode = in_mode;
            assign w_last = in_last;
        end else begin : g_ctl_reg
            // ---- tree stage l: control travels with the data ----
            logic r_vld;
            logic r_mode;
            logic r_last;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= 1'b0;
                    r_mode <= 1'b0;
                    r_last <= 1'b0;
                end else begin
                    r_vld <= g_lvl[l-1].w_vld;
                    if (g_lvl[l-1].w_vld) begin
                        r_mode <= g_lvl[l-1].w_mode;
                        r_last <= g_lvl[l-1].w_last;
                    end
                end
            end

            assign w_vld  = r_vld;
            assign w_mode = r_mode;
            assign w_last = r_last;
        end

        for (genvar j = 0; j < f_nodes(l); j++) begin : g_node
            logic [WIDTH-1:0] w_data;
            logic [IW-1:0]    w_idx;

            if (l == 0) begin : g_src
                assign w_data = in_data[j*WIDTH +: WIDTH];
                assign w_idx  = IW'(j);
            end else begin : g_stage
                logic [WIDTH-1:0] r_data;
                logic [IW-1:0]    r_idx;
                logic [WIDTH-1:0] w_a;
                logic [WIDTH-1:0] w_b;
                logic [IW-1:0]    w_ai;
                logic [IW-1:0]    w_bi;
                logic             w_sel_b;

                assign w_a  = g_lvl[l-1].g_node[2*j].w_data;
                assign w_ai = g_lvl[l-1].g_node[2*j].w_idx;

                if (2*j + 1 < f_nodes(l-1)) begin : g_cmp
                    assign w_b     = g_lvl[l-1].g_node[2*j+1].w_data;
                    assign w_bi    = g_lvl[l-1].g_node[2*j+1].w_idx;
                    assign w_sel_b = f_better(w_b, w_a, g_lvl[l-1].w_mode);
                end else begin : g_pass
                    // Odd leftover: registered bypass keeps every path at L stages.
                    assign w_b     = w_a;
                    assign w_bi    = w_ai;
                    assign w_sel_b = 1'b0;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_data <= '0;
                        r_idx  <= '0;
                    end else if (g_lvl[l-1].w_vld) begin
                        r_data <= w_sel_b ? w_b  : w_a;
                        r_idx  <= w_sel_b ? w_bi : w_ai;
                    end
                end

                assign w_data = r_data;
                assign w_idx  = r_idx;
            end
        end
    end

    logic             w_t_vld;
    logic             w_t_mode;
    logic             w_t_last;
    logic [WIDTH-1:0] w_t_data;
    logic [IW-1:0]    w_t_idx;

    assign w_t_vld  = g_lvl[L].w_vld;
    assign w_t_mode = g_lvl[L].w_mode;
    assign w_t_last = g_lvl[L].w_last;
    assign w_t_data = g_lvl[L].g_node[0].w_data;
    assign w_t_idx  = g_lvl[L].g_node[0].w_idx;

    assign out_valid = w_t_vld;
    assign out_data  = w_t_data;
    assign out_idx   = w_t_idx;

    logic             r_open;
    logic             r_fmode;
    logic             r_err;
    logic [POSW-1:0]  r_pos;
    logic [POSW-1:0]  r_acc_pos;
    logic [WIDTH-1:0] r_acc_data;
    logic [IW-1:0]    r_acc_idx;
    logic             r_fvld;
    logic [WIDTH-1:0] r_fdata;
    logic [IW-1:0]    r_fidx;
    logic [POSW-1:0]  r_fpos;
    logic             r_ferr;

    logic             w_first;
    logic             w_take;
    logic [POSW-1:0]  w_pos;
    logic [POSW-1:0]  w_acc_pos;
    logic [WIDTH-1:0] w_acc_data;
    logic [IW-1:0]    w_acc_idx;
    logic             w_fmode;
    logic             w_err;

    // Later beats are judged under the mode latched by the frame's first beat.
    always_comb begin
        w_first    = !r_open;
        w_pos      = w_first ? '0 : f_sat_inc(r_pos);
        w_take     = w_first || f_better(w_t_data, r_acc_data, r_fmode);
        w_acc_data = w_take ? w_t_data : r_acc_data;
        w_acc_idx  = w_take ? w_t_idx  : r_acc_idx;
        w_acc_pos  = w_take ? w_pos    : r_acc_pos;
        w_fmode    = w_first ? w_t_mode : r_fmode;
        w_err      = w_first ? 1'b0 : (r_err | (w_t_mode != r_fmode));
    end

    // ---- frame stage: one cycle after the tree output ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_open     <= 1'b0;
            r_fmode    <= 1'b0;
            r_err      <= 1'b0;
            r_pos      <= '0;
            r_acc_pos  <= '0;
            r_acc_data <= '0;
            r_acc_idx  <= '0;
            r_fvld     <= 1'b0;
            r_fdata    <= '0;
            r_fidx     <= '0;
            r_fpos     <= '0;
            r_ferr     <= 1'b0;
        end else begin
            r_fvld <= w_t_vld & w_t_last;
            if (w_t_vld) begin
                r_open     <= !w_t_last;
                r_pos      <= w_pos;
                r_acc_pos  <= w_acc_pos;
                r_acc_data <= w_acc_data;
                r_acc_idx  <= w_acc_idx;
                r_fmode    <= w_fmode;
                r_err      <= w_t_last ? 1'b0 : w_err;
                if (w_t_last) begin
                    r_fdata <= w_acc_data;
                    r_fidx  <= w_acc_idx;
                    r_fpos  <= w_acc_pos;
                    r_ferr  <= w_err;
                end
            end
        end
    end

    assign frame_valid = r_fvld;
    assign frame_data  = r_fdata;
    assign frame_idx   = r_fidx;
    assign frame_pos   = r_fpos;
    assign frame_err   = r_ferr;

endmodule

// File: tb/tb_minmax_select_pipe.sv
// Scoreboard bench: three instances (3ch unsigned, 4ch signed, 2ch with a
// 2-bit position counter) driven by scenario tasks.
module tb_minmax_select_pipe;

    typedef struct {
        logic [7:0] d;
        logic [1:0] i;
        int         c;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] i;
        logic [7:0] p;
        logic       e;
        int         c;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: CH=3 unsigned
    logic        a_vld = 0, a_mode = 0, a_last = 0;
    logic [23:0] a_data = '0;
    logic        a_ov, a_fv, a_fe;
    logic [7:0]  a_od, a_fd, a_fp;
    logic [1:0]  a_oi, a_fi;

    minmax_select_pipe #(.WIDTH(8), .CH(3), .SIGNED(0), .POSW(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_data(a_data),
        .in_mode(a_mode), .in_last(a_last), .out_valid(a_ov), .out_data(a_od),
        .out_idx(a_oi), .frame_valid(a_fv), .frame_data(a_fd), .frame_idx(a_fi),
        .frame_pos(a_fp), .frame_err(a_fe)
    );

    // DUT B: CH=4 signed
    logic        b_vld = 0, b_mode = 0, b_last = 0;
    logic [31:0] b_data = '0;
    logic        b_ov, b_fv, b_fe;
    logic [7:0]  b_od, b_fd, b_fp;
    logic [1:0]  b_oi, b_fi;

    minmax_select_pipe #(.WIDTH(8), .CH(4), .SIGNED(1), .POSW(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_data(b_data),
        .in_mode(b_mode), .in_last(b_last), .out_valid(b_ov), .out_data(b_od),
        .out_idx(b_oi), .frame_valid(b_fv), .frame_data(b_fd), .frame_idx(b_fi),
        .frame_pos(b_fp), .frame_err(b_fe)
    );

    // DUT C: CH=2, POSW=2
    logic        c_vld = 0, c_mode = 0, c_last = 0;
    logic [15:0] c_data = '0;
    logic        c_ov, c_fv, c_fe;
    logic [7:0]  c_od, c_fd;
    logic [0:0]  c_oi, c_fi;
    logic [1:0]  c_fp;

    minmax_select_pipe #(.WIDTH(8), .CH(2), .SIGNED(0), .POSW(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_vld), .in_data(c_data),
        .in_mode(c_mode), .in_last(c_last), .out_valid(c_ov), .out_data(c_od),
        .out_idx(c_oi), .frame_valid(c_fv), .frame_data(c_fd), .frame_idx(c_fi),
        .frame_pos(c_fp), .frame_err(c_fe)
    );

    beat_t  qa[$];
    beat_t  qb[$];
    frame_t qfa[$];

    bit         m_open = 0, m_mode = 0, m_err = 0;
    logic [7:0] m_d = '0, m_pos = '0, m_bp = '0;
    logic [1:0] m_i = '0;

    function automatic int f_val(input logic [7:0] x, input bit sgn);
        return sgn ? int'($signed(x)) : int'(x);
    endfunction

    function automatic void f_model(input logic [31:0] data, input int ch, input bit sgn,
                                    input bit mode, output logic [7:0] d, output logic [1:0] i);
        int best, v;
        d    = data[7:0];
        i    = 2'd0;
        best = f_val(d, sgn);
        for (int k = 1; k < ch; k++) begin
            v = f_val(data[k*8 +: 8], sgn);
            if (mode ? (v > best) : (v < best)) begin
                best = v;
                d    = data[k*8 +: 8];
                i    = 2'(k);
            end
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_a(input logic [23:0] d, input bit mode, input bit last);
        beat_t      e;
        frame_t     f;
        logic [7:0] bd;
        logic [1:0] bi;
        a_vld = 1; a_data = d; a_mode = mode; a_last = last;
        f_model({8'h00, d}, 3, 0, mode, bd, bi);
        e.d = bd; e.i = bi; e.c = cyc + 2;
        qa.push_back(e);
        if (!m_open) begin
            m_open = 1; m_d = bd; m_i = bi; m_pos = 0; m_bp = 0; m_mode = mode; m_err = 0;
        end else begin
            if (m_pos != 8'hFF) m_pos = m_pos + 1;
            if (m_mode ? (bd > m_d) : (bd < m_d)) begin
                m_d = bd; m_i = bi; m_bp = m_pos;
            end
            if (mode != m_mode) m_err = 1;
        end
        if (last) begin
            f.d = m_d; f.i = m_i; f.p = m_bp; f.e = m_err; f.c = cyc + 3;
            qfa.push_back(f);
            m_open = 0;
        end
        step(1);
        a_vld = 0; a_last = 0;
    endtask

    task automatic drive_b(input logic [31:0] d, input bit mode);
        beat_t      e;
        logic [7:0] bd;
        logic [1:0] bi;
        b_vld = 1; b_data = d; b_mode = mode; b_last = 1;
        f_model(d, 4, 1, mode, bd, bi);
        e.d = bd; e.i = bi; e.c = cyc + 2;
        qb.push_back(e);
        step(1);
        b_vld = 0; b_last = 0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0 || qfa.size() != 0) && k < 40) begin
            step(1);
            k++;
        end
    endtask

    beat_t      mon_e;
    frame_t     mon_f;
    logic [7:0] hold_d = '0;
    logic [1:0] hold_i = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_d = '0;
            hold_i = '0;
        end else begin
            if (a_ov) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_beat_unexpected: data %0d idx %0d at cycle %0d, required no beat", a_od, a_oi, cyc);
                end else begin
                    mon_e = qa.pop_front();
                    if (a_od !== mon_e.d || a_oi !== mon_e.i || cyc != mon_e.c) begin
                        errors++;
                        $display("FAIL a_beat: data %0d idx %0d cycle %0d, required data %0d idx %0d cycle %0d",
                                 a_od, a_oi, cyc, mon_e.d, mon_e.i, mon_e.c);
                    end
                end
                hold_d = a_od;
                hold_i = a_oi;
            end else begin
                checks++;
                if (a_od !== hold_d || a_oi !== hold_i) begin
                    errors++;
                    $display("FAIL a_hold: data %0d idx %0d, required data %0d idx %0d", a_od, a_oi, hold_d, hold_i);
                end
            end
            if (qa.size() != 0 && qa[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL a_beat_missing: no output by cycle %0d, required data %0d at cycle %0d", cyc, qa[0].d, qa[0].c);
                void'(qa.pop_front());
            end

            if (a_fv) begin
                checks++;
                if (qfa.size() == 0) begin
                    errors++;
                    $display("FAIL a_frame_unexpected: data %0d pos %0d at cycle %0d, required no frame", a_fd, a_fp, cyc);
                end else begin
                    mon_f = qfa.pop_front();
                    if (a_fd !== mon_f.d || a_fi !== mon_f.i || a_fp !== mon_f.p || a_fe !== mon_f.e || cyc != mon_f.c) begin
                        errors++;
                        $display("FAIL a_frame: data %0d idx %0d pos %0d err %0d cycle %0d, required data %0d idx %0d pos %0d err %0d cycle %0d",
                                 a_fd, a_fi, a_fp, a_fe, cyc, mon_f.d, mon_f.i, mon_f.p, mon_f.e, mon_f.c);
                    end
                end
            end
            if (qfa.size() != 0 && qfa[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL a_frame_missing: no frame by cycle %0d, required data %0d at cycle %0d", cyc, qfa[0].d, qfa[0].c);
                void'(qfa.pop_front());
            end

            if (b_ov) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_beat_unexpected: data %0h idx %0d, required no beat", b_od, b_oi);
                end else begin
                    mon_e = qb.pop_front();
                    if (b_od !== mon_e.d || b_oi !== mon_e.i || cyc != mon_e.c) begin
                        errors++;
                        $display("FAIL b_beat: data %0h idx %0d cycle %0d, required data %0h idx %0d cycle %0d",
                                 b_od, b_oi, cyc, mon_e.d, mon_e.i, mon_e.c);
                    end
                end
            end
            if (qb.size() != 0 && qb[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL b_beat_missing: no output by cycle %0d, required data %0h", cyc, qb[0].d);
                void'(qb.pop_front());
            end
        end
    end

    task automatic test_reset();
        step(2);
        checks++;
        if (a_ov !== 0 || a_od !== 0 || a_oi !== 0 || a_fv !== 0 || a_fd !== 0 ||
            a_fi !== 0 || a_fp !== 0 || a_fe !== 0 || b_ov !== 0 || b_od !== 0 || c_ov !== 0 || c_fv !== 0) begin
            errors++;
            $display("FAIL reset_outputs: a_ov %0d a_od %0d a_oi %0d a_fv %0d a_fd %0d a_fp %0d a_fe %0d b_ov %0d, required all 0",
                     a_ov, a_od, a_oi, a_fv, a_fd, a_fp, a_fe, b_ov);
        end
        rst_n = 1;
        step(3);
        checks++;
        if (a_ov !== 0 || a_fv !== 0 || b_ov !== 0 || c_ov !== 0 || c_fv !== 0) begin
            errors++;
            $display("FAIL reset_idle: a_ov %0d a_fv %0d b_ov %0d c_ov %0d, required 0", a_ov, a_fv, b_ov, c_ov);
        end
    endtask

    task automatic test_unsigned_min();
        bit ok = 0;
        drive_a({8'd7, 8'd3, 8'd9}, 0, 1);
        for (int k = 0; k < 6 && !ok; k++) begin
            @(negedge clk);
            ok = a_ov;
        end
        checks++;
        if (!ok || a_od !== 8'd3 || a_oi !== 2'd1) begin
            errors++;
            $display("FAIL unsigned_min: valid %0d data %0d idx %0d, required valid 1 data 3 idx 1", ok, a_od, a_oi);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_tie_max();
        bit ok = 0;
        drive_a({8'd200, 8'd5, 8'd200}, 1, 1);
        for (int k = 0; k < 6 && !ok; k++) begin
            @(negedge clk);
            ok = a_ov;
        end
        checks++;
        if (!ok || a_od !== 8'd200 || a_oi !== 2'd0) begin
            errors++;
            $display("FAIL tie_max: valid %0d data %0d idx %0d, required valid 1 data 200 idx 0", ok, a_od, a_oi);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 2) == 0) step(1);
            drive_a({8'($urandom), 8'($urandom), 8'($urandom)}, 1'($urandom_range(0, 1)),
                    (n == 9) || ($urandom_range(0, 3) == 0));
        end
        for (int n = 0; n < 8; n++) begin
            drive_a({8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))},
                    0, n == 7);
        end
        wait_drain();
        checks++;
        if (qa.size() != 0 || qfa.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_drain: %0d beats %0d frames pending, required 0", qa.size(), qfa.size());
        end
    endtask

    task automatic test_signed();
        bit ok;
        for (int m = 0; m < 2; m++) begin
            ok = 0;
            drive_b({8'h00, 8'hFF, 8'h7F, 8'h80}, 1'(m));
            for (int k = 0; k < 6 && !ok; k++) begin
                @(negedge clk);
                ok = b_ov;
            end
            checks++;
            if (!ok || b_od !== ((m == 0) ? 8'h80 : 8'h7F) || b_oi !== 2'(m)) begin
                errors++;
                $display("FAIL signed_mode%0d: valid %0d data %0h idx %0d, required data %0h idx %0d",
                         m, ok, b_od, b_oi, (m == 0) ? 8'h80 : 8'h7F, m);
            end
            @(posedge clk); #1;
        end
        wait_drain();
    endtask

    task automatic test_frame();
        bit ok;
        for (int flip = 0; flip < 2; flip++) begin
            ok = 0;
            drive_a({8'd12, 8'd50, 8'd40}, 0, 0);
            drive_a({8'd9, 8'd30, 8'd4}, 1'(flip), 0);
            drive_a({8'd4, 8'd4, 8'd60}, 0, 1);
            for (int k = 0; k < 8 && !ok; k++) begin
                @(negedge clk);
                ok = a_fv;
            end
            checks++;
            if (flip == 0) begin
                if (!ok || a_fd !== 8'd4 || a_fi !== 2'd0 || a_fp !== 8'd1 || a_fe !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_basic: valid %0d data %0d idx %0d pos %0d err %0d, required 1 4 0 1 0",
                             ok, a_fd, a_fi, a_fp, a_fe);
                end
            end else begin
                if (!ok || a_fd !== 8'd4 || a_fi !== 2'd1 || a_fp !== 8'd2 || a_fe !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_modeflip: valid %0d data %0d idx %0d pos %0d err %0d, required 1 4 1 2 1",
                             ok, a_fd, a_fi, a_fp, a_fe);
                end
            end
            @(posedge clk); #1;
            wait_drain();
        end
    endtask

    task automatic test_reset_midframe();
        bit ok = 0;
        int pulses = 0;
        drive_a({8'd30, 8'd20, 8'd10}, 0, 0);
        drive_a({8'd31, 8'd21, 8'd11}, 0, 0);
        wait_drain();
        step(1);
        rst_n = 0;
        m_open = 0;
        step(2);
        checks++;
        if (a_fv !== 0 || a_od !== 0 || a_fd !== 0 || a_ov !== 0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: fv %0d od %0d fd %0d ov %0d, required 0", a_fv, a_od, a_fd, a_ov);
        end
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_fv) pulses++;
        end
        @(posedge clk); #1;
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midframe_no_frame: %0d frame pulses, required 0", pulses);
        end
        drive_a({8'd66, 8'd88, 8'd77}, 1, 1);
        for (int k = 0; k < 8 && !ok; k++) begin
            @(negedge clk);
            ok = a_fv;
        end
        checks++;
        if (!ok || a_fd !== 8'd88 || a_fi !== 2'd1 || a_fp !== 8'd0 || a_fe !== 1'b0) begin
            errors++;
            $display("FAIL midframe_single: valid %0d data %0d idx %0d pos %0d err %0d, required 1 88 1 0 0",
                     ok, a_fd, a_fi, a_fp, a_fe);
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_two_channel_saturate();
        bit ok = 0;
        c_vld = 1; c_data = {8'd5, 8'd5}; c_mode = 0; c_last = 1;
        step(1);
        c_vld = 0; c_last = 0;
        @(negedge clk);
        checks++;
        if (c_ov !== 1'b1 || c_od !== 8'd5 || c_oi !== 1'b0) begin
            errors++;
            $display("FAIL two_ch_latency: valid %0d data %0d idx %0d, required 1 5 0", c_ov, c_od, c_oi);
        end
        @(posedge clk); #1;
        step(3);
        for (int k = 0; k < 6; k++) begin
            c_vld = 1; c_data = {8'd200, 8'(100 - k * 10)}; c_mode = 0; c_last = (k == 5);
            step(1);
        end
        c_vld = 0; c_last = 0;
        for (int k = 0; k < 6 && !ok; k++) begin
            @(negedge clk);
            ok = c_fv;
        end
        checks++;
        if (!ok || c_fd !== 8'd50 || c_fi !== 1'b0 || c_fp !== 2'd3 || c_fe !== 1'b0) begin
            errors++;
            $display("FAIL pos_saturate: valid %0d data %0d idx %0d pos %0d err %0d, required 1 50 0 3 0",
                     ok, c_fd, c_fi, c_fp, c_fe);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_unsigned_min();
        test_tie_max();
        test_back_to_back();
        test_signed();
        test_frame();
        test_reset_midframe();
        test_two_channel_saturate();
        step(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
